// File: rtl/parity_frame_checker_pkg.sv
// Shared definitions for the serial parity frame checker: FSM state
// encoding and default widths.
package parity_pkg;

    localparam int PARITY_DATA_W_DEF = 8;
    localparam int ERR_CNT_W         = 8;

    // state   | meaning
    // PC_RECV | collecting data bits then the parity bit (in_ready=1)
    // PC_HOLD | completed frame presented downstream (out_valid=1)
    typedef enum logic {
        PC_RECV = 1'b0,
        PC_HOLD = 1'b1
    } pc_state_e;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Serial-in / word-out handshake bundle for parity_frame_checker.
// master drives bits and the output-side ready; slave is the checker.
interface parity_frame_checker_if
    import parity_pkg::*;
#(
    parameter int DATA_W = PARITY_DATA_W_DEF
);
    logic              in_valid;
    logic              in_bit;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_perr;

    modport master (
        output in_valid,
        output in_bit,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_perr
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_perr
    );
endinterface

// File: rtl/parity_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/parity_frame_checker.sv
// Receive-side even-parity frame checker. Collects DATA_W data bits LSB
// first followed by one parity bit, then presents the word and a parity
// error flag until the consumer takes it.
// Optional feature: define PARCHK_ERR_CNT_EN to add the saturating
// err_cnt output counting handshaked frames that carried a parity error.
//
// state   | meaning
// PC_RECV | accepting bits; idx selects data position or parity slot
// PC_HOLD | frame held on out_*; no bits accepted until out handshake
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = PARITY_DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    parity_frame_checker_if.slave  link
`ifdef PARCHK_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);
    localparam int IDX_W = $clog2(DATA_W + 1);

    pc_state_e         state_q,    state_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              acc_q,      acc_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_perr_q, out_perr_d;

    logic in_ready;
    logic out_valid;
    logic accept;

    // Handshake qualifiers depend on state only, so in_ready never sees out_ready.
    always_comb begin
        in_ready  = (state_q == PC_RECV);
        out_valid = (state_q == PC_HOLD);
        accept    = link.in_valid & in_ready;
    end

    // Next-state and datapath update; clr overrides any frame progress.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        shift_d    = shift_q;
        out_data_d = out_data_q;
        out_perr_d = out_perr_q;

        unique case (state_q)
            PC_RECV: begin
                if (accept) begin
                    if (idx_q == IDX_W'(DATA_W)) begin
                        out_data_d = shift_q;
                        out_perr_d = acc_q ^ link.in_bit;
                        idx_d      = '0;
                        acc_d      = 1'b0;
                        state_d    = PC_HOLD;
                    end else begin
                        // Positional write: every frame rewrites all bits,
                        // so an aborted frame leaves nothing visible.
                        for (int i = 0; i < DATA_W; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                shift_d[i] = link.in_bit;
                            end
                        end
                        acc_d = acc_q ^ link.in_bit;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PC_HOLD: begin
                if (link.out_ready) begin
                    state_d = PC_RECV;
                end
            end
            default: begin
                state_d = PC_RECV;
            end
        endcase

        if (clr) begin
            state_d    = PC_RECV;
            idx_d      = '0;
            acc_d      = 1'b0;
            out_data_d = out_data_q;
            out_perr_d = out_perr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PC_RECV;
            idx_q      <= '0;
            acc_q      <= 1'b0;
            shift_q    <= '0;
            out_data_q <= '0;
            out_perr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            shift_q    <= shift_d;
            out_data_q <= out_data_d;
            out_perr_q <= out_perr_d;
        end
    end

    assign link.in_ready  = in_ready;
    assign link.out_valid = out_valid;
    assign link.out_data  = out_data_q;
    assign link.out_perr  = out_perr_q;

`ifdef PARCHK_ERR_CNT_EN
    logic err_inc;

    // A bad frame counts only when actually consumed without a concurrent abort.
    always_comb begin
        err_inc = out_valid & link.out_ready & out_perr_q & ~clr;
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker; covers the err_cnt option when
// PARCHK_ERR_CNT_EN is defined.
module tb_parity_frame_checker;
    import parity_pkg::*;

    logic clk;
    logic rst_n;
    logic clr;
    int   n_checks;
    int   n_pass;
    int   cyc;

    parity_frame_checker_if #(.DATA_W(8)) link ();

`ifdef PARCHK_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    parity_frame_checker #(
        .DATA_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .link    (link)
`ifdef PARCHK_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t required finish", $time);
        $fatal(1);
    end

    // Drives n bits LSB first; starts and ends at a falling edge.
    task automatic send_bits(input logic [15:0] bits, input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            link.in_valid = 1'b1;
            link.in_bit   = bits[i];
            guard = 0;
            while (link.in_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_checks++;
                $display("FAIL send_bits_ready_timeout: in_ready=%b after %0d cycles, required 1", link.in_ready, guard);
                break;
            end
            @(negedge clk);
        end
        link.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        clr            = 1'b0;
        link.in_valid  = 1'b0;
        link.in_bit    = 1'b0;
        link.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (link.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", link.in_ready); else n_pass++;
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", link.out_valid); else n_pass++;
        n_checks++; if (link.out_data !== 8'h00) $display("FAIL reset_out_data: got %h required 00", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL reset_out_perr: got %b required 0", link.out_perr); else n_pass++;
`ifdef PARCHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d required 0", err_cnt); else n_pass++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        link.out_ready = 1'b1;
        send_bits(16'h00A5, 8);
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL good_valid_early: got %b required 0", link.out_valid); else n_pass++;
        n_checks++; if (link.in_ready !== 1'b1) $display("FAIL good_ready_before_parity: got %b required 1", link.in_ready); else n_pass++;
        send_bits(16'h0000, 1);
        n_checks++; if (link.out_valid !== 1'b1) $display("FAIL good_valid: got %b required 1", link.out_valid); else n_pass++;
        n_checks++; if (link.out_data !== 8'hA5) $display("FAIL good_data: got %h required a5", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL good_perr: got %b required 0", link.out_perr); else n_pass++;
        n_checks++; if (link.in_ready !== 1'b0) $display("FAIL good_ready_in_hold: got %b required 0", link.in_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL good_valid_after_hs: got %b required 0", link.out_valid); else n_pass++;
        n_checks++; if (link.in_ready !== 1'b1) $display("FAIL good_ready_after_hs: got %b required 1", link.in_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        link.out_ready = 1'b0;
        send_bits(16'h003C, 9);
        // Offer a stray bit during HOLD; it must not be taken.
        link.in_valid = 1'b1;
        link.in_bit   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (link.out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b required 1", k, link.out_valid); else n_pass++;
            n_checks++; if (link.out_data !== 8'h3C) $display("FAIL bp_data[%0d]: got %h required 3c", k, link.out_data); else n_pass++;
            n_checks++; if (link.out_perr !== 1'b0) $display("FAIL bp_perr[%0d]: got %b required 0", k, link.out_perr); else n_pass++;
            n_checks++; if (link.in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b required 0", k, link.in_ready); else n_pass++;
            @(negedge clk);
        end
        link.in_valid  = 1'b0;
        link.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL bp_valid_release: got %b required 0", link.out_valid); else n_pass++;
        n_checks++; if (link.in_ready !== 1'b1) $display("FAIL bp_ready_release: got %b required 1", link.in_ready); else n_pass++;
    endtask

    task automatic test_bad_frame();
        link.out_ready = 1'b1;
        send_bits(16'h0001, 9);
        n_checks++; if (link.out_data !== 8'h01) $display("FAIL bad_data: got %h required 01", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b1) $display("FAIL bad_perr: got %b required 1", link.out_perr); else n_pass++;
`ifdef PARCHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL bad_err_cnt_before: got %0d required 0", err_cnt); else n_pass++;
`endif
        @(negedge clk);
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL bad_valid_after_hs: got %b required 0", link.out_valid); else n_pass++;
`ifdef PARCHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL bad_err_cnt_after: got %0d required 1", err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_clr();
        link.out_ready = 1'b1;
        // Partial frame then abort.
        send_bits(16'h000B, 4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++; if (link.in_ready !== 1'b1) $display("FAIL clr_ready: got %b required 1", link.in_ready); else n_pass++;
        send_bits(16'h00FF, 8);
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL clr_residue_valid: got %b required 0", link.out_valid); else n_pass++;
        send_bits(16'h0000, 1);
        n_checks++; if (link.out_valid !== 1'b1) $display("FAIL clr_frame_valid: got %b required 1", link.out_valid); else n_pass++;
        n_checks++; if (link.out_data !== 8'hFF) $display("FAIL clr_frame_data: got %h required ff", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL clr_frame_perr: got %b required 0", link.out_perr); else n_pass++;
        @(negedge clk);
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL clr_single_output: got %b required 0", link.out_valid); else n_pass++;

        // clr coinciding with the parity-bit accept loses the frame.
        send_bits(16'h0055, 8);
        link.in_valid = 1'b1;
        link.in_bit   = 1'b1;
        clr           = 1'b1;
        @(negedge clk);
        clr           = 1'b0;
        link.in_valid = 1'b0;
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL clr_parity_valid: got %b required 0", link.out_valid); else n_pass++;
        n_checks++; if (link.out_data !== 8'hFF) $display("FAIL clr_parity_data_kept: got %h required ff", link.out_data); else n_pass++;
        send_bits(16'h0055, 9);
        n_checks++; if (link.out_data !== 8'h55) $display("FAIL clr_after_data: got %h required 55", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL clr_after_perr: got %b required 0", link.out_perr); else n_pass++;
        @(negedge clk);

        // clr coinciding with the out handshake of a bad frame.
        send_bits(16'h0001, 9);
        n_checks++; if (link.out_perr !== 1'b1) $display("FAIL clr_hs_perr: got %b required 1", link.out_perr); else n_pass++;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL clr_hs_valid: got %b required 0", link.out_valid); else n_pass++;
`ifdef PARCHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL clr_hs_err_cnt: got %0d required 1", err_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_frame();
        link.out_ready = 1'b1;
        send_bits(16'h00FF, 6);
        rst_n = 1'b0;
        #1;
        n_checks++; if (link.in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b required 1", link.in_ready); else n_pass++;
        n_checks++; if (link.out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b required 0", link.out_valid); else n_pass++;
        n_checks++; if (link.out_data !== 8'h00) $display("FAIL rstmid_data: got %h required 00", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL rstmid_perr: got %b required 0", link.out_perr); else n_pass++;
`ifdef PARCHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL rstmid_err_cnt: got %0d required 0", err_cnt); else n_pass++;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_bits(16'h0180, 9);
        n_checks++; if (link.out_valid !== 1'b1) $display("FAIL rstmid_frame_valid: got %b required 1", link.out_valid); else n_pass++;
        n_checks++; if (link.out_data !== 8'h80) $display("FAIL rstmid_frame_data: got %h required 80", link.out_data); else n_pass++;
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL rstmid_frame_perr: got %b required 0", link.out_perr); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        int c3;
        link.out_ready = 1'b1;
        send_bits(16'h0012, 9);
        c1 = cyc;
        n_checks++; if (link.out_data !== 8'h12 || link.out_perr !== 1'b0) $display("FAIL b2b_f1: got %h/%b required 12/0", link.out_data, link.out_perr); else n_pass++;
        send_bits(16'h017E, 9);
        c2 = cyc;
        n_checks++; if (link.out_data !== 8'h7E || link.out_perr !== 1'b1) $display("FAIL b2b_f2: got %h/%b required 7e/1", link.out_data, link.out_perr); else n_pass++;
        send_bits(16'h00C0, 9);
        c3 = cyc;
        n_checks++; if (link.out_data !== 8'hC0 || link.out_perr !== 1'b0) $display("FAIL b2b_f3: got %h/%b required c0/0", link.out_data, link.out_perr); else n_pass++;
        n_checks++; if (c2 - c1 !== 10) $display("FAIL b2b_period12: got %0d required 10", c2 - c1); else n_pass++;
        n_checks++; if (c3 - c2 !== 10) $display("FAIL b2b_period23: got %0d required 10", c3 - c2); else n_pass++;
        @(negedge clk);
`ifdef PARCHK_ERR_CNT_EN
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL b2b_err_cnt: got %0d required 1", err_cnt); else n_pass++;
`endif
    endtask

`ifdef PARCHK_ERR_CNT_EN
    task automatic test_err_saturation();
        link.out_ready = 1'b1;
        for (int f = 0; f < 100; f++) send_bits(16'h0001, 9);
        @(negedge clk);
        n_checks++; if (err_cnt !== 8'd101) $display("FAIL sat_mid: got %0d required 101", err_cnt); else n_pass++;
        for (int f = 0; f < 200; f++) send_bits(16'h0001, 9);
        @(negedge clk);
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_full: got %0d required 255", err_cnt); else n_pass++;
        send_bits(16'h00A5, 9);
        n_checks++; if (link.out_perr !== 1'b0) $display("FAIL sat_good_perr: got %b required 0", link.out_perr); else n_pass++;
        @(negedge clk);
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_after_good: got %0d required 255", err_cnt); else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_good_frame();
        test_backpressure();
        test_bad_frame();
        test_clr();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef PARCHK_ERR_CNT_EN
        test_err_saturation();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
